// File: rtl/s2mm_frame_addr_gen.sv
// Write-side frame sequencer: requests a buffer from the mutex controller on each stream SOF,
// then issues one S2MM datamover write command per image line (addr = base + line*stride).
module s2mm_frame_addr_gen #(
    parameter int C_ADDR_WIDTH  = 32,
    parameter int C_IMG_WBITS   = 12,
    parameter int C_IMG_HBITS   = 12,
    parameter int C_PIXEL_BYTES = 4,
    parameter int C_BTT_WIDTH   = 23
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [C_IMG_WBITS-1:0]  img_width,
    input  logic [C_IMG_HBITS-1:0]  img_height,
    input  logic [C_ADDR_WIDTH-1:0] line_stride,
    input  logic                    s_sof,
    output logic                    frm_sof,
    input  logic [C_ADDR_WIDTH-1:0] frm_addr,
    output logic                    cmd_valid,
    input  logic                    cmd_ready,
    output logic [C_ADDR_WIDTH-1:0] cmd_addr,
    output logic [C_BTT_WIDTH-1:0]  cmd_btt,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    frame_skip,
    output logic                    overrun
);

    localparam int C_PB_SHIFT = $clog2(C_PIXEL_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SOF,
        S_LATCH,
        S_CMD,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_pend_sof,   w_pend_sof_nxt;
    logic [C_IMG_HBITS-1:0]  r_line,       w_line_nxt;
    logic [C_IMG_HBITS-1:0]  r_height,     w_height_nxt;
    logic [C_ADDR_WIDTH-1:0] r_stride,     w_stride_nxt;
    logic [C_ADDR_WIDTH-1:0] r_cmd_addr,   w_cmd_addr_nxt;
    logic [C_BTT_WIDTH-1:0]  r_cmd_btt,    w_cmd_btt_nxt;
    logic                    r_cmd_valid,  w_cmd_valid_nxt;
    logic                    r_frm_sof,    w_frm_sof_nxt;
    logic                    r_busy,       w_busy_nxt;
    logic                    r_frame_done, w_frame_done_nxt;
    logic                    r_frame_skip, w_frame_skip_nxt;
    logic                    r_overrun,    w_overrun_nxt;
    logic                    w_fire;
    logic                    w_last_line;

    assign w_fire      = r_cmd_valid & cmd_ready;
    assign w_last_line = (r_line == r_height - C_IMG_HBITS'(1));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_pend_sof_nxt  = r_pend_sof;
        w_line_nxt      = r_line;
        w_height_nxt    = r_height;
        w_stride_nxt    = r_stride;
        w_cmd_addr_nxt  = r_cmd_addr;
        w_cmd_btt_nxt   = r_cmd_btt;
        w_cmd_valid_nxt = r_cmd_valid;
        w_frame_skip_nxt = 1'b0;
        w_overrun_nxt    = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (s_sof || r_pend_sof) begin
                    w_state_nxt    = S_SOF;
                    w_pend_sof_nxt = 1'b0;
                end
            end
            S_SOF: begin
                w_state_nxt = S_LATCH;
            end
            S_LATCH: begin
                w_height_nxt = img_height;
                w_stride_nxt = line_stride;
                if (frm_addr == '0) begin
                    w_frame_skip_nxt = 1'b1;
                    w_state_nxt      = S_IDLE;
                end else if (img_width == '0 || img_height == '0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_cmd_addr_nxt  = frm_addr;
                    w_cmd_btt_nxt   = C_BTT_WIDTH'(img_width) << C_PB_SHIFT;
                    w_line_nxt      = '0;
                    w_cmd_valid_nxt = 1'b1;
                    w_state_nxt     = S_CMD;
                end
            end
            S_CMD: begin
                // Address and btt only move on a handshake, keeping the command stable while stalled.
                if (w_fire) begin
                    w_line_nxt     = r_line + C_IMG_HBITS'(1);
                    w_cmd_addr_nxt = r_cmd_addr + r_stride;
                    if (w_last_line) begin
                        w_cmd_valid_nxt = 1'b0;
                        w_state_nxt     = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (r_pend_sof) begin
                    w_state_nxt    = S_SOF;
                    w_pend_sof_nxt = 1'b0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // A SOF seen mid-frame is remembered once; it overrides the clear above.
        if (s_sof && r_state != S_IDLE) begin
            w_overrun_nxt  = 1'b1;
            w_pend_sof_nxt = 1'b1;
        end

        w_frm_sof_nxt    = (w_state_nxt == S_SOF);
        w_frame_done_nxt = (w_state_nxt == S_DONE);
        w_busy_nxt       = (w_state_nxt != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_pend_sof   <= 1'b0;
            r_line       <= '0;
            r_height     <= '0;
            r_stride     <= '0;
            r_cmd_addr   <= '0;
            r_cmd_btt    <= '0;
            r_cmd_valid  <= 1'b0;
            r_frm_sof    <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_skip <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pend_sof   <= w_pend_sof_nxt;
            r_line       <= w_line_nxt;
            r_height     <= w_height_nxt;
            r_stride     <= w_stride_nxt;
            r_cmd_addr   <= w_cmd_addr_nxt;
            r_cmd_btt    <= w_cmd_btt_nxt;
            r_cmd_valid  <= w_cmd_valid_nxt;
            r_frm_sof    <= w_frm_sof_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_frame_skip <= w_frame_skip_nxt;
            r_overrun    <= w_overrun_nxt;
        end
    end

    assign frm_sof    = r_frm_sof;
    assign cmd_valid  = r_cmd_valid;
    assign cmd_addr   = r_cmd_addr;
    assign cmd_btt    = r_cmd_btt;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign frame_skip = r_frame_skip;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_s2mm_frame_addr_gen.sv
// Directed bench for s2mm_frame_addr_gen: inputs driven and outputs sampled on the falling edge.
module tb_s2mm_frame_addr_gen;

    localparam int AW = 32;
    localparam int WB = 12;
    localparam int HB = 12;
    localparam int BW = 23;

    // Flag vector layout: {frm_sof, cmd_valid, busy, frame_done, frame_skip, overrun}
    localparam logic [5:0] F_IDLE  = 6'b000000;
    localparam logic [5:0] F_SOF   = 6'b101000;
    localparam logic [5:0] F_LATCH = 6'b001000;
    localparam logic [5:0] F_CMD   = 6'b011000;
    localparam logic [5:0] F_CMDOV = 6'b011001;
    localparam logic [5:0] F_DONE  = 6'b001100;
    localparam logic [5:0] F_SKIP  = 6'b000010;
    localparam logic [5:0] F_SKPOV = 6'b000011;

    logic          clk = 1'b0;
    logic          resetn;
    logic [WB-1:0] img_width;
    logic [HB-1:0] img_height;
    logic [AW-1:0] line_stride;
    logic          s_sof;
    logic          frm_sof;
    logic [AW-1:0] frm_addr;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [BW-1:0] cmd_btt;
    logic          busy;
    logic          frame_done;
    logic          frame_skip;
    logic          overrun;
    logic [5:0]    flags;

    int n_cmp = 0;
    int n_err = 0;

    assign flags = {frm_sof, cmd_valid, busy, frame_done, frame_skip, overrun};

    always #5 clk = ~clk;

    s2mm_frame_addr_gen #(
        .C_ADDR_WIDTH (AW),
        .C_IMG_WBITS  (WB),
        .C_IMG_HBITS  (HB),
        .C_PIXEL_BYTES(4),
        .C_BTT_WIDTH  (BW)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .img_width  (img_width),
        .img_height (img_height),
        .line_stride(line_stride),
        .s_sof      (s_sof),
        .frm_sof    (frm_sof),
        .frm_addr   (frm_addr),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_btt    (cmd_btt),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_skip (frame_skip),
        .overrun    (overrun)
    );

    // Drives a one-cycle s_sof; returns at the falling edge where the SOF state is visible.
    task automatic pulse_sof();
        @(negedge clk) s_sof = 1'b1;
        @(negedge clk) s_sof = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({flags, cmd_addr, cmd_btt} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got flags=%b addr=%h btt=%0d expected all zero", flags, cmd_addr, cmd_btt);
        end
        resetn = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (flags !== F_IDLE) begin
            n_err++;
            $display("FAIL reset_idle: got flags=%b expected %b", flags, F_IDLE);
        end
    endtask

    task automatic test_basic_frame();
        img_width = 12'd640; img_height = 12'd4; line_stride = 32'd4096;
        frm_addr = 32'h1000_0000; cmd_ready = 1'b1;
        pulse_sof();
        n_cmp++;
        if (flags !== F_SOF) begin
            n_err++; $display("FAIL basic_sof: got flags=%b expected %b", flags, F_SOF);
        end
        @(negedge clk);
        n_cmp++;
        if (flags !== F_LATCH) begin
            n_err++; $display("FAIL basic_latch: got flags=%b expected %b", flags, F_LATCH);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (flags !== F_CMD || cmd_addr !== 32'h1000_0000 + 32'(i) * 32'h1000 || cmd_btt !== 23'd2560) begin
                n_err++;
                $display("FAIL basic_cmd%0d: got flags=%b addr=%h btt=%0d expected flags=%b addr=%h btt=2560",
                         i, flags, cmd_addr, cmd_btt, F_CMD, 32'h1000_0000 + 32'(i) * 32'h1000);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (flags !== F_DONE) begin
            n_err++; $display("FAIL basic_done: got flags=%b expected %b", flags, F_DONE);
        end
        @(negedge clk);
        n_cmp++;
        if (flags !== F_IDLE) begin
            n_err++; $display("FAIL basic_idle: got flags=%b expected %b", flags, F_IDLE);
        end
    endtask

    task automatic test_backpressure();
        img_width = 12'd640; img_height = 12'd4; line_stride = 32'd4096;
        frm_addr = 32'h1000_0000; cmd_ready = 1'b1;
        pulse_sof();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (flags !== F_CMD || cmd_addr !== 32'h1000_2000) begin
            n_err++; $display("FAIL bp_line2: got flags=%b addr=%h expected %b 10002000", flags, cmd_addr, F_CMD);
        end
        cmd_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++;
            if (flags !== F_CMD || cmd_addr !== 32'h1000_2000 || cmd_btt !== 23'd2560) begin
                n_err++;
                $display("FAIL bp_stall%0d: got flags=%b addr=%h btt=%0d expected %b 10002000 2560",
                         k, flags, cmd_addr, cmd_btt, F_CMD);
            end
        end
        cmd_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (flags !== F_CMD || cmd_addr !== 32'h1000_3000) begin
            n_err++; $display("FAIL bp_line3: got flags=%b addr=%h expected %b 10003000", flags, cmd_addr, F_CMD);
        end
        @(negedge clk);
        n_cmp++;
        if (flags !== F_DONE) begin
            n_err++; $display("FAIL bp_done: got flags=%b expected %b", flags, F_DONE);
        end
        @(negedge clk);
    endtask

    // Skipped frame with a second SOF arriving during LATCH: pending SOF served from IDLE.
    task automatic test_skip();
        img_width = 12'd640; img_height = 12'd4; line_stride = 32'd4096;
        frm_addr = 32'h0; cmd_ready = 1'b1;
        pulse_sof();
        n_cmp++;
        if (flags !== F_SOF) begin
            n_err++; $display("FAIL skip_sof: got flags=%b expected %b", flags, F_SOF);
        end
        @(negedge clk) s_sof = 1'b1;
        @(negedge clk) s_sof = 1'b0;
        n_cmp++;
        if (flags !== F_SKPOV) begin
            n_err++; $display("FAIL skip_pulse: got flags=%b expected %b", flags, F_SKPOV);
        end
        @(negedge clk);
        n_cmp++;
        if (flags !== F_SOF) begin
            n_err++; $display("FAIL skip_pend_sof: got flags=%b expected %b", flags, F_SOF);
        end
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (flags !== F_SKIP) begin
            n_err++; $display("FAIL skip_second: got flags=%b expected %b", flags, F_SKIP);
        end
        @(negedge clk);
        n_cmp++;
        if (flags !== F_IDLE) begin
            n_err++; $display("FAIL skip_idle: got flags=%b expected %b", flags, F_IDLE);
        end
    endtask

    task automatic test_overrun();
        img_width = 12'd640; img_height = 12'd4; line_stride = 32'd4096;
        frm_addr = 32'h1000_0000; cmd_ready = 1'b1;
        pulse_sof();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s_sof = (i == 1);
            n_cmp++;
            if (flags !== ((i == 2) ? F_CMDOV : F_CMD) || cmd_addr !== 32'h1000_0000 + 32'(i) * 32'h1000) begin
                n_err++;
                $display("FAIL ovr_cmd%0d: got flags=%b addr=%h expected flags=%b addr=%h",
                         i, flags, cmd_addr, (i == 2) ? F_CMDOV : F_CMD, 32'h1000_0000 + 32'(i) * 32'h1000);
            end
        end
        @(negedge clk);
        s_sof = 1'b0;
        frm_addr = 32'h0;
        n_cmp++;
        if (flags !== F_DONE) begin
            n_err++; $display("FAIL ovr_done: got flags=%b expected %b", flags, F_DONE);
        end
        @(negedge clk);
        n_cmp++;
        if (flags !== F_SOF) begin
            n_err++; $display("FAIL ovr_pend_sof: got flags=%b expected %b", flags, F_SOF);
        end
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (flags !== F_SKIP) begin
            n_err++; $display("FAIL ovr_pend_skip: got flags=%b expected %b", flags, F_SKIP);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_size();
        logic [WB-1:0] w_tab [2];
        logic [HB-1:0] h_tab [2];
        w_tab[0] = 12'd640; h_tab[0] = 12'd0;
        w_tab[1] = 12'd0;   h_tab[1] = 12'd4;
        frm_addr = 32'h2000_0000; line_stride = 32'd4096; cmd_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            img_width = w_tab[t]; img_height = h_tab[t];
            pulse_sof();
            n_cmp++;
            if (flags !== F_SOF) begin
                n_err++; $display("FAIL zero%0d_sof: got flags=%b expected %b", t, flags, F_SOF);
            end
            @(negedge clk);
            @(negedge clk);
            n_cmp++;
            if (flags !== F_DONE) begin
                n_err++; $display("FAIL zero%0d_done: got flags=%b expected %b", t, flags, F_DONE);
            end
            @(negedge clk);
            n_cmp++;
            if (flags !== F_IDLE) begin
                n_err++; $display("FAIL zero%0d_idle: got flags=%b expected %b", t, flags, F_IDLE);
            end
        end
    endtask

    task automatic test_wrap_reset();
        img_width = 12'd640; img_height = 12'd2; line_stride = 32'h1000;
        frm_addr = 32'hFFFF_F000; cmd_ready = 1'b0;
        pulse_sof();
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (flags !== F_CMD || cmd_addr !== 32'hFFFF_F000) begin
            n_err++; $display("FAIL wrap_line0: got flags=%b addr=%h expected %b fffff000", flags, cmd_addr, F_CMD);
        end
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        n_cmp++;
        if (flags !== F_CMD || cmd_addr !== 32'h0000_0000) begin
            n_err++; $display("FAIL wrap_line1: got flags=%b addr=%h expected %b 00000000", flags, cmd_addr, F_CMD);
        end
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({flags, cmd_addr, cmd_btt} !== '0) begin
            n_err++;
            $display("FAIL midframe_reset: got flags=%b addr=%h btt=%0d expected all zero", flags, cmd_addr, cmd_btt);
        end
        resetn = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (flags !== F_IDLE) begin
            n_err++; $display("FAIL post_reset_idle: got flags=%b expected %b", flags, F_IDLE);
        end
    endtask

    initial begin
        resetn = 1'b0; s_sof = 1'b0; cmd_ready = 1'b0;
        img_width = '0; img_height = '0; line_stride = '0; frm_addr = '0;
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_skip();
        test_overrun();
        test_zero_size();
        test_wrap_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
